// File: rtl/vec_pkg.sv
// Shared widths, types and write-mask constants for the vector register file.
// Imported by the register file, its scoreboard and the ALU-side glue.
package vec_pkg;

    localparam int NREGS  = 16;
    localparam int VLEN   = 256;
    localparam int LANE_W = 16;
    localparam int NLANES = VLEN / LANE_W;
    localparam int FLAG_W = 64;
    localparam int AW     = $clog2(NREGS);

    typedef logic [VLEN-1:0]   vreg_t;
    typedef logic [AW-1:0]     vaddr_t;
    typedef logic [NLANES-1:0] lane_mask_t;

    localparam lane_mask_t MASK_SCALAR = 16'h0001;
    localparam lane_mask_t MASK_VECTOR = 16'hFFFF;

endpackage

// File: rtl/vec_scoreboard.sv
// Pending-destination tracker and issue stall for the vector register file.
// A same-cycle write-back resolves a hazard because the read path bypasses it.
module vec_scoreboard
    import vec_pkg::*;
#(
    parameter int NREGS = vec_pkg::NREGS,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_dst,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    output logic             stall,
    output logic [NREGS-1:0] pending
);

    logic [NREGS-1:0] clr_vec;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] eff;

    always_comb begin
        clr_vec = '0;
        if (we)
            clr_vec = NREGS'(1) << wa;
        eff   = pending & ~clr_vec;
        stall = iss_valid && (eff[ra1] || eff[ra2] || eff[iss_dst]);
        set_vec = '0;
        if (iss_valid && !stall)
            set_vec = NREGS'(1) << iss_dst;
    end

    // Set is applied after clear so a same-cycle issue keeps its bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pending <= '0;
        else
            pending <= (pending & ~clr_vec) | set_vec;
    end

endmodule

// File: rtl/vec_regfile.sv
// Vector register file: two bypassed read ports, lane-masked write-back,
// issue scoreboard and sticky ALU flag accumulator.
module vec_regfile
    import vec_pkg::*;
#(
    parameter int NREGS  = vec_pkg::NREGS,
    parameter int VLEN   = vec_pkg::VLEN,
    parameter int LANE_W = vec_pkg::LANE_W,
    parameter int FLAG_W = vec_pkg::FLAG_W,
    localparam int NLANES = VLEN / LANE_W,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     ra1,
    input  logic [AW-1:0]     ra2,
    output logic [VLEN-1:0]   rd1,
    output logic [VLEN-1:0]   rd2,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_dst,
    output logic              stall,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [VLEN-1:0]   wd,
    input  logic [NLANES-1:0] wmask,
    input  logic              flags_we,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic              flags_clr,
    output logic [FLAG_W-1:0] sticky_flags,
    output logic [NREGS-1:0]  pending
);

    logic [VLEN-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++)
                regs[r] <= '0;
        end else if (we) begin
            for (int i = 0; i < NLANES; i++)
                if (wmask[i])
                    regs[wa][i*LANE_W +: LANE_W] <= wd[i*LANE_W +: LANE_W];
        end
    end

    // Lane-wise bypass makes a write-back visible in its own cycle.
    always_comb begin
        rd1 = regs[ra1];
        rd2 = regs[ra2];
        for (int i = 0; i < NLANES; i++) begin
            if (we && wa == ra1 && wmask[i])
                rd1[i*LANE_W +: LANE_W] = wd[i*LANE_W +: LANE_W];
            if (we && wa == ra2 && wmask[i])
                rd2[i*LANE_W +: LANE_W] = wd[i*LANE_W +: LANE_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sticky_flags <= '0;
        else if (flags_clr)
            sticky_flags <= flags_we ? flags_in : '0;
        else if (flags_we)
            sticky_flags <= sticky_flags | flags_in;
    end

    vec_scoreboard #(
        .NREGS(NREGS)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .ra1       (ra1),
        .ra2       (ra2),
        .iss_valid (iss_valid),
        .iss_dst   (iss_dst),
        .we        (we),
        .wa        (wa),
        .stall     (stall),
        .pending   (pending)
    );

endmodule

// File: doc/vec_regfile.md
# vec_regfile

Vector register file and issue scoreboard directly upstream of the vector ALU. Holds 16 × 256-bit vector registers (16 lanes of 16-bit Q8.8), drives the ALU `a`/`b` operands from two combinational read ports, and accepts lane-masked write-back of ALU results. Tracks in-flight destinations to raise a stall on read-after-write and write-after-write hazards, and accumulates the ALU's 64-bit lane flags into a sticky status register.

## Interface
- `NREGS`, 16: number of vector registers; power of two.
- `VLEN`, 256: vector width in bits.
- `LANE_W`, 16: lane width in bits; `NLANES = VLEN/LANE_W` (16).
- `FLAG_W`, 64: flags width from the ALU, 4 per lane.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ra1`, `ra2`  in  $clog2(NREGS)  read addresses.
- `rd1`, `rd2`  out  VLEN  read data; `rd1` feeds ALU `a`, `rd2` feeds ALU `b`.
- `iss_valid`  in  1  an instruction requests issue this cycle.
- `iss_dst`  in  $clog2(NREGS)  destination register of the issuing instruction.
- `stall`  out  1  issue blocked this cycle; combinational.
- `we`  in  1  write-back enable.
- `wa`  in  $clog2(NREGS)  write-back address.
- `wd`  in  VLEN  write-back data (ALU `result`).
- `wmask`  in  NLANES  per-lane write enable; bit i covers `wd[16i+15:16i]`.
- `flags_we`  in  1  accumulate `flags_in` into the sticky register.
- `flags_in`  in  FLAG_W  ALU `flags`.
- `flags_clr`  in  1  clear the sticky register.
- `sticky_flags`  out  FLAG_W  accumulated flags.
- `pending`  out  NREGS  scoreboard state, for debug and verification.

## Operation
- Reads: `rd1 = reg[ra1]`, `rd2 = reg[ra2]`, with per-lane write bypass: if `we && wa==ra1 && wmask[i]`, lane i of `rd1` is `wd` lane i. The same rule applies to `rd2`.
- Writes: on the clock edge with `we`, each lane i where `wmask[i]` is set is written. Unmasked lanes keep their value.
- Scalar write-back uses `wmask = 16'h0001` (lane 0 = bits [15:0]). Vector write-back uses `16'hFFFF`. `wmask = 0` with `we` writes nothing but still clears the pending bit.
- Scoreboard: `pending[iss_dst]` is set when `iss_valid && !stall`. `pending[wa]` is cleared when `we`.
  - Set and clear of the same register in the same cycle: the set wins.
- Effective pending: `eff(r) = pending[r] && !(we && wa==r)`. A same-cycle write-back counts as resolved because of the bypass.
- `stall = iss_valid && (eff(ra1) || eff(ra2) || eff(iss_dst))`. `stall` is 0 whenever `iss_valid` is 0.
- Sticky flags, per edge:
  - `flags_clr` only: cleared to 0.
  - `flags_we` only: OR-accumulates `flags_in`.
  - Both: `sticky_flags = flags_in` (clear first, then accumulate).
- Out-of-range addresses cannot occur because `NREGS` is a power of two.

## Timing
- Reset (`rst_n` low, asynchronous): all registers 0, `pending = 0`, `sticky_flags = 0`.
  - `rd1`/`rd2` become 0 immediately, unless bypassed by a write already on the bus.
  - `stall` follows its combinational equation with `pending = 0`.
- Reset asserted mid-operation discards all pending state. Write-back arriving after reset deassertion writes normally; its clear is a no-op.
- Read latency is 0 cycles (combinational). Write latency is 1 edge. Bypass makes a write visible in the same cycle.
- `pending` and `sticky_flags` update 1 edge after their enabling inputs.
- Stall is combinational from `iss_valid`, the addresses and `we`/`wa`. There is no internal handshake; the issuer holds its request while `stall` is 1.

## Structure
- Package `vec_pkg`: `VLEN`, `LANE_W`, `NLANES`, `FLAG_W`, `NREGS`, typedef `vreg_t` (logic [VLEN-1:0]), typedef `vaddr_t`, typedef `lane_mask_t`, and constants `MASK_SCALAR = 16'h0001`, `MASK_VECTOR = 16'hFFFF`.
- Sub-module `vec_scoreboard`: holds the pending vector, set/clear priority logic and the stall equation. The register array, bypass and sticky flags stay in `vec_regfile`.

## Test plan
- Reset, then write v1 = `0180_0140_0380_0180_0080_0300_0140_0000_…_0140` with mask `FFFF`; read `ra1=1` next cycle -> `rd1` equals the written value exactly. Assert `rst_n` low mid-run -> `rd1=0`, `pending=0`, `sticky_flags=0` without waiting for a clock edge.
- Preload v2 = all `FE80`; scalar write `wd=…_0000_0240` with mask `0001` -> v2 lane 0 = `0240`, lanes 1–15 remain `FE80`. Same-cycle read of `ra2=2` already shows lane 0 = `0240` (bypass).
- Issue with dst=3 and no stall -> `pending[3]=1`. Then issue with `ra1=3` -> `stall=1`. Then assert `we`, `wa=3` in the same cycle as that issue -> `stall=0` and `rd1` = `wd`.
- In one cycle, issue dst=4 while a write-back clears v4 -> `pending[4]` stays 1. Issue dst=4 again next cycle -> `stall=1` (WAW).
- `flags_we` with `0000_…_0001`, then with `8000_…_0000` -> `sticky_flags = 8000_…_0001`. Assert `flags_clr` and `flags_we` (`flags_in = 0F`) together -> `sticky_flags = 0F`.
- `iss_valid=0` with every register pending -> `stall=0`. `we=1` with `wmask=0` on v5 -> v5 unchanged and `pending[5]` cleared.
